int_rs_collapse_mw: RTL
=======================

Name: int_rs_collapse_mw

Overview:
- Parametrised successor of the single-issue ordered integer reservation station.
- Age-ordered collapsing queue: slot 0 always holds the oldest entry.
- Accepts up to DISPATCH_W uops per cycle from dispatch, wakes source operands from CDB_W broadcast tags, and issues up to ISSUE_W oldest ready entries per cycle on independent FU lanes.
- Compacts by any number of holes in one cycle. Sits between dispatch and the integer FU issue registers.

Parameters:
- DEPTH, 16, number of RS entries (>= DISPATCH_W, >= ISSUE_W).
- DISPATCH_W, 2, dispatch lanes per cycle.
- ISSUE_W, 2, issue lanes per cycle.
- CDB_W, 2, wakeup broadcast ports.
- PRF_IDX_W, 6, physical register tag width.
- PAYLOAD_W, 64, opaque payload bits (rob_id, rd, opcode, imm, selects), carried untouched.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush: invalidate all entries.
- dispatch_valid  in  DISPATCH_W  per-lane uop valid.
- dispatch_ready  out  1  all lanes may dispatch this cycle.
- dispatch_rs1_phy / dispatch_rs2_phy  in  DISPATCH_W*PRF_IDX_W  source tags.
- dispatch_rs1_rdy / dispatch_rs2_rdy  in  DISPATCH_W  source already available.
- dispatch_payload  in  DISPATCH_W*PAYLOAD_W  payload.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_rd_phy  in  CDB_W*PRF_IDX_W  broadcast tag.
- issue_valid  out  ISSUE_W  lane k holds the k-th oldest ready entry.
- issue_ready  in  ISSUE_W  FU lane accepts.
- issue_rs1_phy / issue_rs2_phy  out  ISSUE_W*PRF_IDX_W  to PRF read ports.
- issue_payload  out  ISSUE_W*PAYLOAD_W  payload.
- occupancy  out  $clog2(DEPTH+1)  valid entry count (registered).

Behaviour:
- Reset (rst_n low, async): all entries invalid, occupancy=0, issue_valid=0, dispatch_ready=1 once out of reset.
- Entry ready = valid & rs1_rdy & rs2_rdy, from registered state only. An entry woken by CDB at edge N can issue no earlier than cycle N+1.
- Select: scan slot 0 upward. The k-th ready slot drives lane k. issue_valid is contiguous from lane 0.
- issue_valid and issue data must not depend combinationally on issue_ready.
- Lane k fires iff issue_valid[k] & issue_ready[k]. Lanes fire independently, so a younger entry may leave while an older one stalls.
- Fired slots are removed at the edge. Survivors shift down by the count of fired slots below them, preserving order.
- Dispatch:
  - Accepted lanes = dispatch_valid & dispatch_ready.
  - Accepted lanes are packed in lane order and written starting at slot (occupancy - fired_count).
  - Lane 0 is the oldest of the group; gaps in dispatch_valid are skipped.
- dispatch_ready = (DEPTH - occupancy) >= DISPATCH_W. Conservative: ignores same-cycle issue, and has no combinational path from issue_ready.
- Wakeup:
  - Each cycle, every valid entry compares rs1/rs2 tags against all valid CDB tags and sets the matching rdy bit.
  - Incoming dispatch uops are also compared, so a tag broadcast in their dispatch cycle is not lost.
  - Shifted entries carry their updated rdy bits.
- Occupancy next = occupancy - fired + accepted. It never exceeds DEPTH and never underflows; assert both.
- Flush: at the edge all entries are invalidated and occupancy=0. Same-cycle dispatch is discarded. issue_valid is forced 0 in the flush cycle.
- Full: DEPTH-occupancy < DISPATCH_W drops dispatch_ready. Issue continues.
- Empty: issue_valid=0. Dispatched uops appear on issue lanes at the earliest one cycle later.
- Mid-operation reset: async clear of all state regardless of handshakes in flight.

Optional Feature:
- Macro INT_RS_CDB_BYPASS_EN.
- Defined: entry ready also includes same-cycle CDB tag matches, so an entry woken at cycle N issues in cycle N. This adds a combinational path from cdb_* to issue_*.
- Undefined: ready uses registered rdy bits only (baseline above). No combinational path from cdb_* to issue_*.

Test Plan:
- Reset then dispatch 2 uops, both sources rdy -> next cycle issue_valid=2'b11; lane0 carries the payload of dispatch lane0; occupancy 2 -> 0 after both fire.
- Fill to 16 with unready sources -> dispatch_ready=0 at occupancy 15 and 16. Broadcast CDB tag 5 matching slots 3 and 9 -> next cycle lane0=slot3, lane1=slot9.
- Slots 0..3 ready, issue_ready=2'b10 -> only slot1 fires; next cycle old slot0 stays at slot0 and old slot2 moves to slot1; order checked against a reference queue.
- Dispatch uop with rs1 tag 7 unready while cdb_rd_phy=7 valid in the same cycle -> entry stored rs1_rdy=1; issues the following cycle (INT_RS_CDB_BYPASS_EN undefined).
- Occupancy 10, two fire and two dispatch in the same cycle -> new entries land at slots 8 and 9; occupancy stays 10.
- flush with dispatch_valid=2'b11 and 6 entries -> occupancy 0 next cycle, no issue in the flush cycle. rst_n pulsed low mid-cycle -> outputs clear immediately.

Source files
------------

// File: rtl/int_rs_collapse_mw.sv
// ---------------------------------------------------------------------------
// int_rs_collapse_mw
//
// Multi-issue, age-ordered collapsing reservation station for the integer
// pipe. Slot 0 always holds the oldest valid entry. Valid entries are always
// packed contiguously from slot 0.
//
// Each cycle the block does the following:
//   - Issue: it scans from slot 0 upward. The k-th ready entry drives issue
//     lane k. A lane fires on issue_valid & issue_ready.
//   - Compaction: fired slots are removed. Survivors shift down by the number
//     of fired slots below them. Any number of holes closes in one cycle.
//   - Dispatch: accepted dispatch lanes are packed in lane order behind the
//     survivors.
//   - Wakeup: every stored entry and every incoming uop compares its source
//     tags against all valid CDB tags. A match sets the ready bit.
//
// Optional build macro: INT_RS_CDB_BYPASS_EN
//   Defined   : same-cycle CDB matches also count toward issue readiness. This
//               creates a combinational path from cdb_* to issue_*.
//   Undefined : issue readiness comes only from the registered ready bits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drops every entry at the next edge and blanks issue
//                       in the flush cycle
//   dispatch_*          DISPATCH_W dispatch lanes; dispatch_ready is shared
//   cdb_valid/rd_phy    CDB_W wakeup broadcast ports
//   issue_*             ISSUE_W issue lanes; issue_ready is per lane
//   occupancy           registered count of valid entries
// ---------------------------------------------------------------------------
module int_rs_collapse_mw #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int ISSUE_W    = 2,
  parameter int CDB_W      = 2,
  parameter int PRF_IDX_W  = 6,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [DISPATCH_W-1:0]           dispatch_valid,
  output logic                            dispatch_ready,
  input  logic [DISPATCH_W*PRF_IDX_W-1:0] dispatch_rs1_phy,
  input  logic [DISPATCH_W*PRF_IDX_W-1:0] dispatch_rs2_phy,
  input  logic [DISPATCH_W-1:0]           dispatch_rs1_rdy,
  input  logic [DISPATCH_W-1:0]           dispatch_rs2_rdy,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_payload,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W*PRF_IDX_W-1:0]      cdb_rd_phy,
  output logic [ISSUE_W-1:0]              issue_valid,
  input  logic [ISSUE_W-1:0]              issue_ready,
  output logic [ISSUE_W*PRF_IDX_W-1:0]    issue_rs1_phy,
  output logic [ISSUE_W*PRF_IDX_W-1:0]    issue_rs2_phy,
  output logic [ISSUE_W*PAYLOAD_W-1:0]    issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  // Registered per-slot state.
  logic                 valid_reg    [DEPTH];
  logic                 rs1_rdy_reg  [DEPTH];
  logic                 rs2_rdy_reg  [DEPTH];
  logic [PRF_IDX_W-1:0] rs1_reg      [DEPTH];
  logic [PRF_IDX_W-1:0] rs2_reg      [DEPTH];
  logic [PAYLOAD_W-1:0] payload_reg  [DEPTH];
  logic [OCC_W-1:0]     occupancy_reg;

  // Next-state values after compaction and dispatch.
  logic                 valid_next   [DEPTH];
  logic                 rs1_rdy_next [DEPTH];
  logic                 rs2_rdy_next [DEPTH];
  logic [PRF_IDX_W-1:0] rs1_next     [DEPTH];
  logic [PRF_IDX_W-1:0] rs2_next     [DEPTH];
  logic [PAYLOAD_W-1:0] payload_next [DEPTH];
  logic [OCC_W-1:0]     occupancy_next;

  logic [DEPTH-1:0]      rs1_woke, rs2_woke, slot_ready, slot_fire;
  logic [DISPATCH_W-1:0] disp_rs1_woke, disp_rs2_woke;

  // These values are kept for the occupancy range assertions.
  int occ_sum;
  int fired_total;

  function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0]       tag,
                                   input logic [CDB_W-1:0]           vld,
                                   input logic [CDB_W*PRF_IDX_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (vld[c] && (tags[c*PRF_IDX_W +: PRF_IDX_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign dispatch_ready = (DEPTH - int'(occupancy_reg)) >= DISPATCH_W;
  assign occupancy      = occupancy_reg;

  // Per-slot wakeup and readiness.
  // The *_woke bits are the ready bits that the entry will carry into the
  // next cycle, wherever the entry lands after compaction.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign rs1_woke[gi] = rs1_rdy_reg[gi] | cdb_hit(rs1_reg[gi], cdb_valid, cdb_rd_phy);
      assign rs2_woke[gi] = rs2_rdy_reg[gi] | cdb_hit(rs2_reg[gi], cdb_valid, cdb_rd_phy);
`ifdef INT_RS_CDB_BYPASS_EN
      assign slot_ready[gi] = valid_reg[gi] & rs1_woke[gi] & rs2_woke[gi];
`else
      assign slot_ready[gi] = valid_reg[gi] & rs1_rdy_reg[gi] & rs2_rdy_reg[gi];
`endif
    end

    for (gi = 0; gi < DISPATCH_W; gi++) begin : g_disp
      assign disp_rs1_woke[gi] = dispatch_rs1_rdy[gi] |
        cdb_hit(dispatch_rs1_phy[gi*PRF_IDX_W +: PRF_IDX_W], cdb_valid, cdb_rd_phy);
      assign disp_rs2_woke[gi] = dispatch_rs2_rdy[gi] |
        cdb_hit(dispatch_rs2_phy[gi*PRF_IDX_W +: PRF_IDX_W], cdb_valid, cdb_rd_phy);
    end
  endgenerate

  // Oldest-first select.
  // rank counts the ready slots below slot i. A slot with rank k drives
  // lane k, so issue_valid is contiguous from lane 0. issue_ready only
  // controls slot_fire; it never feeds back into the lane contents.
  always_comb begin
    int rank;
    rank          = 0;
    issue_valid   = '0;
    issue_rs1_phy = '0;
    issue_rs2_phy = '0;
    issue_payload = '0;
    slot_fire     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_ready[i]) begin
        for (int k = 0; k < ISSUE_W; k++) begin
          if (rank == k) begin
            issue_valid[k]                           = ~flush;
            issue_rs1_phy[k*PRF_IDX_W +: PRF_IDX_W]  = rs1_reg[i];
            issue_rs2_phy[k*PRF_IDX_W +: PRF_IDX_W]  = rs2_reg[i];
            issue_payload[k*PAYLOAD_W +: PAYLOAD_W]  = payload_reg[i];
            slot_fire[i]                             = ~flush & issue_ready[k];
          end
        end
        rank = rank + 1;
      end
    end
  end

  // Compaction and dispatch placement.
  // Each destination slot j selects one of two sources:
  //   - the survivor whose (index - fired_below) equals j, or
  //   - the accepted dispatch lane whose packed position lands on j.
  // These sources are disjoint: survivors fill 0..base-1 and new uops fill
  // from base upward.
  always_comb begin
    int fired_below [DEPTH+1];
    int acc_below   [DISPATCH_W+1];
    int base;

    fired_below[0] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      fired_below[i+1] = fired_below[i] + (slot_fire[i] ? 1 : 0);
    end

    acc_below[0] = 0;
    for (int d = 0; d < DISPATCH_W; d++) begin
      acc_below[d+1] = acc_below[d] +
                       ((dispatch_valid[d] && dispatch_ready && !flush) ? 1 : 0);
    end

    base        = int'(occupancy_reg) - fired_below[DEPTH];
    fired_total = fired_below[DEPTH];
    occ_sum     = base + acc_below[DISPATCH_W];

    for (int j = 0; j < DEPTH; j++) begin
      valid_next[j]   = 1'b0;
      rs1_rdy_next[j] = 1'b0;
      rs2_rdy_next[j] = 1'b0;
      rs1_next[j]     = '0;
      rs2_next[j]     = '0;
      payload_next[j] = '0;

      // A survivor only moves toward slot 0, so sources start at j.
      for (int i = j; i < DEPTH; i++) begin
        if (valid_reg[i] && !slot_fire[i] && ((i - fired_below[i]) == j)) begin
          valid_next[j]   = 1'b1;
          rs1_rdy_next[j] = rs1_woke[i];
          rs2_rdy_next[j] = rs2_woke[i];
          rs1_next[j]     = rs1_reg[i];
          rs2_next[j]     = rs2_reg[i];
          payload_next[j] = payload_reg[i];
        end
      end

      for (int d = 0; d < DISPATCH_W; d++) begin
        if (dispatch_valid[d] && dispatch_ready && !flush &&
            ((base + acc_below[d]) == j)) begin
          valid_next[j]   = 1'b1;
          rs1_rdy_next[j] = disp_rs1_woke[d];
          rs2_rdy_next[j] = disp_rs2_woke[d];
          rs1_next[j]     = dispatch_rs1_phy[d*PRF_IDX_W +: PRF_IDX_W];
          rs2_next[j]     = dispatch_rs2_phy[d*PRF_IDX_W +: PRF_IDX_W];
          payload_next[j] = dispatch_payload[d*PAYLOAD_W +: PAYLOAD_W];
        end
      end

      if (flush) valid_next[j] = 1'b0;
    end

    occupancy_next = flush ? '0 : OCC_W'(occ_sum);
  end

  // Control state uses the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy_reg <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        valid_reg[j]   <= 1'b0;
        rs1_rdy_reg[j] <= 1'b0;
        rs2_rdy_reg[j] <= 1'b0;
      end
    end else begin
      occupancy_reg <= occupancy_next;
      for (int j = 0; j < DEPTH; j++) begin
        valid_reg[j]   <= valid_next[j];
        rs1_rdy_reg[j] <= rs1_rdy_next[j];
        rs2_rdy_reg[j] <= rs2_rdy_next[j];
      end
    end
  end

  // Tags and payload are qualified by valid_reg, so they need no reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      rs1_reg[j]     <= rs1_next[j];
      rs2_reg[j]     <= rs2_next[j];
      payload_reg[j] <= payload_next[j];
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (occ_sum <= DEPTH);
      assert (fired_total <= int'(occupancy_reg));
    end
  end

endmodule
